// File: rtl/square_accumulator_multi.sv
// square_accumulator_multi
//   Multi-channel, multi-sample-per-clock sum-of-squares integrator.
//   Each lane carries a magnitude a.
//   Each sample is accumulated as a*(a+1).
//   The 1/4 term of (2a+1)^2/4 is left for the consumer to add back.
//   Sums run over len+1 ce-qualified clocks and are then dumped to
//   accum_o together with a one-cycle valid_o pulse.
//   Pipeline: input capture -> per-lane square -> per-channel lane sum
//   -> accumulate/dump. A sample captured at edge E0 appears at E3.
//   Optional build macro: SQACC_SATURATE_EN
//     defined     : accumulators clamp at all-ones and raise a sticky
//                   per-channel overflow flag, reported on ovf_o at dump.
//     not defined : accumulators wrap and ovf_o stays 0.
module square_accumulator_multi #(
    parameter int NBITS    = 4,
    parameter int NSAMP    = 4,
    parameter int NCHAN    = 2,
    parameter int ACC_BITS = 24,
    parameter int CNT_BITS = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ce_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0]    in_i,
    input  logic [CNT_BITS-1:0]             len_i,
    output logic [NCHAN*ACC_BITS-1:0]       accum_o,
    output logic                            valid_o,
    output logic [NCHAN-1:0]                ovf_o
);

    localparam int NLANE     = NCHAN * NSAMP;
    localparam int SQ_BITS   = 2 * NBITS;
    localparam int SUM_BITS  = SQ_BITS + $clog2(NSAMP);
    localparam int WIDE_BITS = ACC_BITS + 1;

    // a*(a+1) never exceeds 2^(2*NBITS)-2^NBITS, so SQ_BITS is enough
    function automatic logic [SQ_BITS-1:0] square_f(input logic [NBITS-1:0] a);
        logic [SQ_BITS-1:0] aw;
        aw = SQ_BITS'(a);
        return aw * (aw + SQ_BITS'(1));
    endfunction

    logic [NLANE*NBITS-1:0]    in_r;
    logic                      ce0_r;
    logic [SQ_BITS-1:0]        sq_r   [NLANE];
    logic                      ce1_r;
    logic [SUM_BITS-1:0]       sum_s  [NCHAN];
    logic [SUM_BITS-1:0]       sum_r  [NCHAN];
    logic                      ce2_r;
    logic [NCHAN*ACC_BITS-1:0] acc_r;
    logic [NCHAN*ACC_BITS-1:0] nacc_s;
    logic [NCHAN-1:0]          nst_s;
    logic [CNT_BITS-1:0]       cnt_r;
    logic [CNT_BITS-1:0]       len_r;

    // Stage 0: capture raw magnitudes and their qualifier
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_r  <= '0;
            ce0_r <= 1'b0;
        end else begin
            in_r  <= in_i;
            ce0_r <= ce_i;
        end
    end

    // Stage 1: per-lane a*(a+1)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NLANE; i++) begin
                sq_r[i] <= '0;
            end
            ce1_r <= 1'b0;
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                sq_r[i] <= square_f(in_r[i*NBITS +: NBITS]);
            end
            ce1_r <= ce0_r;
        end
    end

    // Per-channel sum of the lane squares
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            sum_s[c] = '0;
            for (int s = 0; s < NSAMP; s++) begin
                sum_s[c] = sum_s[c] + SUM_BITS'(sq_r[c*NSAMP+s]);
            end
        end
    end

    // Stage 2: register the per-channel lane sums
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                sum_r[c] <= '0;
            end
            ce2_r <= 1'b0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                sum_r[c] <= sum_s[c];
            end
            ce2_r <= ce1_r;
        end
    end

`ifdef SQACC_SATURATE_EN
    logic [NCHAN-1:0]     ovf_st_r;
    logic [WIDE_BITS-1:0] wide_s;

    // Next accumulator value with clamp; clamping sets the sticky flag
    always_comb begin
        nacc_s = '0;
        nst_s  = '0;
        wide_s = '0;
        for (int c = 0; c < NCHAN; c++) begin
            wide_s = {1'b0, acc_r[c*ACC_BITS +: ACC_BITS]} + WIDE_BITS'(sum_r[c]);
            if (wide_s[ACC_BITS]) begin
                nacc_s[c*ACC_BITS +: ACC_BITS] = {ACC_BITS{1'b1}};
                nst_s[c] = 1'b1;
            end else begin
                nacc_s[c*ACC_BITS +: ACC_BITS] = wide_s[ACC_BITS-1:0];
                nst_s[c] = ovf_st_r[c];
            end
        end
    end

    // Sticky overflow state, cleared together with the accumulator
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_st_r <= '0;
        end else if (ce2_r) begin
            if (cnt_r == len_r) begin
                ovf_st_r <= '0;
            end else begin
                ovf_st_r <= nst_s;
            end
        end else begin
            ovf_st_r <= ovf_st_r;
        end
    end
`else
    // Next accumulator value, wrapping modulo 2^ACC_BITS; no overflow reporting
    always_comb begin
        nacc_s = '0;
        nst_s  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            nacc_s[c*ACC_BITS +: ACC_BITS] =
                acc_r[c*ACC_BITS +: ACC_BITS] + ACC_BITS'(sum_r[c]);
        end
    end
`endif

    // Stage 3: accumulate ce-qualified sums, dump on the terminal count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r   <= '0;
            cnt_r   <= '0;
            len_r   <= len_i;
            accum_o <= '0;
            ovf_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (ce2_r) begin
                if (cnt_r == len_r) begin
                    // The terminal sample is folded into the dumped value so
                    // back-to-back periods lose nothing.
                    accum_o <= nacc_s;
                    ovf_o   <= nst_s;
                    valid_o <= 1'b1;
                    acc_r   <= '0;
                    cnt_r   <= '0;
                    len_r   <= len_i;
                end else begin
                    acc_r   <= nacc_s;
                    cnt_r   <= cnt_r + CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_square_accumulator_multi.sv
// Self-checking bench for square_accumulator_multi.
// A period-level reference model runs alongside every test and is compared
// each cycle. Directed sequences add hand-computed expectations.
module tb_square_accumulator_multi;

    localparam int NBITS    = 4;
    localparam int NSAMP    = 4;
    localparam int NCHAN    = 2;
    localparam int ACC_BITS = 24;
    localparam int CNT_BITS = 16;
    localparam longint ACC_MAX = (64'd1 << ACC_BITS) - 64'd1;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          ce = 1'b0;
    logic [NCHAN*NSAMP*NBITS-1:0]  in_v = '0;
    logic [CNT_BITS-1:0]           len = '0;
    logic [NCHAN*ACC_BITS-1:0]     accum;
    logic                          valid;
    logic [NCHAN-1:0]              ovf;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    square_accumulator_multi #(
        .NBITS(NBITS), .NSAMP(NSAMP), .NCHAN(NCHAN),
        .ACC_BITS(ACC_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_i(in_v), .len_i(len),
        .accum_o(accum), .valid_o(valid), .ovf_o(ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // all lanes of ch0 = a0, all lanes of ch1 = a1
    function automatic logic [NCHAN*NSAMP*NBITS-1:0] pack(input int a0, input int a1);
        logic [NCHAN*NSAMP*NBITS-1:0] v;
        v = '0;
        for (int s = 0; s < NSAMP; s++) begin
            v[s*NBITS +: NBITS]         = NBITS'(a0);
            v[(NSAMP+s)*NBITS +: NBITS] = NBITS'(a1);
        end
        return v;
    endfunction

    // sample energy of one channel: sum over lanes of a*(a+1)
    function automatic longint energy(input logic [NCHAN*NSAMP*NBITS-1:0] v, input int c);
        longint e;
        longint a;
        e = 0;
        for (int s = 0; s < NSAMP; s++) begin
            a = longint'(v[(c*NSAMP+s)*NBITS +: NBITS]);
            e += a * (a + 1);
        end
        return e;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        longint due;
        longint e [NCHAN];
    } smp_t;

    smp_t   q [$];
    longint cyc = 0;
    longint m_acc [NCHAN];
    longint m_cnt = 0;
    longint m_len = 0;
    logic [NCHAN-1:0]          m_ovf = '0;
    logic [NCHAN*ACC_BITS-1:0] e_acc = '0;
    logic [NCHAN-1:0]          e_ovf = '0;
    logic                      e_valid = 1'b0;

    // model: each ce-high sample lands 3 edges after capture, reset drops all
    always @(posedge clk) begin
        smp_t   it;
        smp_t   nw;
        longint t;
        cyc++;
        if (rst) begin
            q.delete();
            for (int c = 0; c < NCHAN; c++) m_acc[c] = 0;
            m_cnt = 0;
            m_len = longint'(len);
            m_ovf = '0;
            e_acc = '0;
            e_ovf = '0;
            e_valid = 1'b0;
        end else begin
            e_valid = 1'b0;
            while (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                for (int c = 0; c < NCHAN; c++) begin
                    t = m_acc[c] + it.e[c];
`ifdef SQACC_SATURATE_EN
                    if (t > ACC_MAX) begin
                        t = ACC_MAX;
                        m_ovf[c] = 1'b1;
                    end
`else
                    t = t & ACC_MAX;
`endif
                    m_acc[c] = t;
                end
                if (m_cnt == m_len) begin
                    for (int c = 0; c < NCHAN; c++) begin
                        e_acc[c*ACC_BITS +: ACC_BITS] = ACC_BITS'(m_acc[c]);
                        m_acc[c] = 0;
                    end
                    e_ovf = m_ovf;
                    e_valid = 1'b1;
                    m_ovf = '0;
                    m_cnt = 0;
                    m_len = longint'(len);
                end else begin
                    m_cnt++;
                end
            end
            if (ce) begin
                nw.due = cyc + 3;
                for (int c = 0; c < NCHAN; c++) nw.e[c] = energy(in_v, c);
                q.push_back(nw);
            end
        end
    end

    // compare DUT against model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", 64'(valid), 64'(e_valid));
            check("model_accum", 64'(accum), 64'(e_acc));
            check("model_ovf", 64'(ovf), 64'(e_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [CNT_BITS-1:0] l);
        rst = 1'b1;
        ce = 1'b0;
        in_v = '0;
        len = l;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        int                  a;
        logic [ACC_BITS-1:0] exp0;
    } vec_t;

    vec_t vec [16];

    initial begin
        int pulses;
        int first_at;
        int prev_at;
        logic [ACC_BITS-1:0] got [2];
        int exp_tab [16];
        exp_tab = '{0, 2, 6, 12, 20, 30, 42, 56, 72, 90, 110, 132, 156, 182, 210, 240};
        for (int i = 0; i < 16; i++) begin
            vec[i].a = i;
            vec[i].exp0 = ACC_BITS'(exp_tab[i]);
        end

        // reset state
        do_reset(16'd0);
        chk_en = 1'b1;
        check("reset_accum", 64'(accum), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);

        // 1: len=0, ch0 lane0 ramps, each output 3 clocks after its input
        ce = 1'b1;
        for (int i = 0; i < 19; i++) begin
            in_v = '0;
            if (i < 16) in_v[NBITS-1:0] = NBITS'(vec[i].a);
            step();
            if (i >= 3) begin
                check("t1_valid", 64'(valid), 64'd1);
                check("t1_ch0", 64'(accum[ACC_BITS-1:0]), 64'(vec[i-3].exp0));
                check("t1_ch1", 64'(accum[2*ACC_BITS-1:ACC_BITS]), 64'd0);
            end
        end
        ce = 1'b0;
        repeat (4) step();

        // 2: len=3, four samples, one pulse three clocks after the fourth
        do_reset(16'd3);
        in_v = pack(1, 15);
        ce = 1'b1;
        repeat (4) step();
        ce = 1'b0;
        pulses = 0;
        first_at = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i;
                    check("t2_ch0", 64'(accum[ACC_BITS-1:0]), 64'd32);
                    check("t2_ch1", 64'(accum[2*ACC_BITS-1:ACC_BITS]), 64'd3840);
                end
            end
        end
        check("t2_pulses", 64'(pulses), 64'd1);
        check("t2_latency", 64'(first_at), 64'd2);

        // 3: len=1, ce alternating: 48 per pulse, a pulse every 4 clocks
        do_reset(16'd1);
        in_v = pack(2, 0);
        pulses = 0;
        prev_at = -1;
        for (int i = 0; i < 28; i++) begin
            ce = (i < 20) && (i % 2 == 0);
            step();
            if (valid) begin
                pulses++;
                check("t3_ch0", 64'(accum[ACC_BITS-1:0]), 64'd48);
                if (prev_at >= 0) check("t3_spacing", 64'(i - prev_at), 64'd4);
                prev_at = i;
            end
        end
        check("t3_pulses", 64'(pulses), 64'd5);

        // 4: len=1, continuous ce, ramp 1..4: 4*(2+6)=32 then 4*(12+20)=128
        do_reset(16'd1);
        pulses = 0;
        prev_at = -1;
        for (int i = 0; i < 10; i++) begin
            ce = (i < 4);
            in_v = (i < 4) ? pack(i + 1, 0) : '0;
            step();
            if (valid) begin
                if (pulses < 2) got[pulses] = accum[ACC_BITS-1:0];
                if (prev_at >= 0) check("t4_gap", 64'(i - prev_at), 64'd2);
                prev_at = i;
                pulses++;
            end
        end
        check("t4_pulses", 64'(pulses), 64'd2);
        check("t4_p0", 64'(got[0]), 64'd32);
        check("t4_p1", 64'(got[1]), 64'd128);

        // 6: reset mid-period discards the partial sum
        do_reset(16'd3);
        in_v = pack(5, 5);
        ce = 1'b1;
        pulses = 0;
        repeat (2) begin
            step();
            if (valid) pulses++;
        end
        rst = 1'b1;
        ce = 1'b0;
        step();
        rst = 1'b0;
        check("t6_rst_accum", 64'(accum), 64'd0);
        in_v = pack(1, 0);
        ce = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) ce = 1'b0;
            step();
            if (valid) begin
                pulses++;
                check("t6_ch0", 64'(accum[ACC_BITS-1:0]), 64'd32);
            end
        end
        check("t6_pulses", 64'(pulses), 64'd1);

        // random: segments with random length, ce, data and occasional resets
        for (int seg = 0; seg < 6; seg++) begin
            do_reset(CNT_BITS'($urandom_range(0, 4)));
            for (int i = 0; i < 250; i++) begin
                ce = ($urandom_range(0, 3) != 0);
                in_v = NCHAN*NSAMP*NBITS'($urandom);
                rst = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 19) == 0) len = CNT_BITS'($urandom_range(0, 4));
                step();
            end
            rst = 1'b0;
            ce = 1'b0;
            repeat (5) step();
        end

        // 5: longest period, full-scale input on both channels
        do_reset(16'hFFFF);
        in_v = pack(15, 15);
        ce = 1'b1;
        for (int i = 0; i < 65600 && !valid; i++) begin
            if (i == 65536) ce = 1'b0;
            step();
        end
        ce = 1'b0;
        check("t5_valid", 64'(valid), 64'd1);
`ifdef SQACC_SATURATE_EN
        check("t5_accum", 64'(accum), 64'hFFFFFF_FFFFFF);
        check("t5_ovf", 64'(ovf), 64'd3);
`else
        check("t5_accum", 64'(accum), 64'hC00000_C00000);
        check("t5_ovf", 64'(ovf), 64'd0);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
